map_bus_wr_capture: RTL and testbench
=====================================

Name: map_bus_wr_capture

Overview:
- Upstream of the nibble-register mapper core. Samples the asynchronous cartridge CPU bus (M2, R/W, address, data) in the system clock domain.
- Detects qualified M2 falling edges on writes inside a programmable address window and queues each write as an {addr, data} record in a small FIFO.
- The mapper register file pops records with a valid/ready handshake, so no write is lost while the core is busy, e.g. during save-state register access.

Parameters:
- SYNC_STAGES, 2, depth of the M2 synchronizer and of the matching bus delay pipeline (≥2)
- MIN_HIGH, 3, minimum consecutive clk cycles of synchronized M2 high before a falling edge is accepted (glitch filter)
- ADDR_MASK, 16'h8000, address bits compared for the window
- ADDR_MATCH, 16'h8000, required value of the masked address
- DEPTH, 4, FIFO entries (power of two)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m2  in  1  raw CPU M2 pin
- cpu_rw  in  1  raw CPU R/W (0 = write)
- cpu_addr  in  16  raw CPU address
- cpu_data  in  8  raw CPU data
- hold  in  1  when 1, accepted edges are discarded (save-state active)
- wr_valid  out  1  FIFO head valid
- wr_addr  out  16  head record address
- wr_data  out  8  head record data
- wr_ready  in  1  consumer pops head when wr_valid & wr_ready
- fifo_cnt  out  log2(DEPTH)+1  occupancy
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async, rst=1):
  - Sync chain, delay pipeline, hi_cnt and capture registers all cleared.
  - FIFO emptied.
  - wr_valid=0, wr_addr=0, wr_data=0, fifo_cnt=0, ovf=0.
  - Sync chain resets to 0, so no falling edge is produced on release.
  - Reset mid-transaction drops queued and in-flight writes.
- Synchronization:
  - m2 passes through SYNC_STAGES flops to give m2_s.
  - {cpu_rw, cpu_addr, cpu_data} pass through an equal-length register pipeline, giving bus_s aligned with m2_s.
  - m2_d is m2_s delayed one cycle.
- Capture:
  - Each cycle that m2_s=1, cap_rw/cap_addr/cap_data are loaded from bus_s.
  - The captured values are therefore those present at the last raw clk sample with M2 high.
- hi_cnt:
  - Saturating counter of m2_s=1 cycles, width ≥ clog2(MIN_HIGH+1).
  - Cleared when m2_s=0.
- Edge acceptance:
  - fall = m2_d & !m2_s & (hi_cnt ≥ MIN_HIGH).
  - hi_cnt is the value before clearing, i.e. registered.
  - accept = fall & !cap_rw & ((cap_addr & ADDR_MASK) == ADDR_MATCH) & !hold.
- Push: when accept=1 on a clk edge, {cap_addr, cap_data} is written at the tail.
- Latency: raw m2 sampled low at edge k → wr_valid high after edge k+SYNC_STAGES+1 (FIFO previously empty).
- Pop: on an edge with wr_valid & wr_ready, the head advances. wr_ready with wr_valid=0 has no effect.
- Head outputs:
  - wr_addr/wr_data are registered copies of the head entry.
  - They remain stable while wr_valid=1 and wr_ready=0.
  - When the FIFO is empty they hold their last value.
- Full:
  - accept while full and no pop in the same cycle → record dropped, ovf<=1.
  - accept and pop in the same cycle while full → both happen, no overflow, occupancy stays DEPTH.
- Empty: accept and wr_ready in the same cycle while empty → push only. The new record appears next cycle; it does not bypass to the outputs.
- fifo_cnt = pushes − pops, range 0..DEPTH. Pointers wrap modulo DEPTH.
- ovf:
  - Set by a dropped record; cleared by ovf_clr.
  - Set wins if both occur in the same cycle.
- hold: suppresses only pushes. Pops, sync and capture continue; a discarded edge is not counted as overflow.
- Reads (cpu_rw=1) and out-of-window writes never push.

Test Plan:
- Single write: M2 high 8 clks, rw=0, addr 16'h8001, data 8'h5A; M2 falls; wr_ready=0 → wr_valid rises SYNC_STAGES+1 clks after the fall with wr_addr=8001, wr_data=5A, fifo_cnt=1. Raise wr_ready → pop, fifo_cnt=0, wr_valid=0.
- Glitch and window filtering:
  - M2 high pulse of 2 clks (MIN_HIGH=3) with a write to 8000 → no push.
  - Full-length write to 16'h6000 → no push.
  - Read (rw=1) to 8000 → no push.
- Overflow: 5 writes to E000..E004 with wr_ready=0 → fifo_cnt=4, ovf=1; pop order yields E000, E001, E002, E003; ovf stays 1 until ovf_clr.
- Full push+pop: FIFO full, wr_ready=1 on the same cycle as accepting a write to F001 → ovf=0, fifo_cnt=4, last entry F001.
- hold: hold=1 during a write to A000 → no push, ovf=0. Entries queued beforehand still pop normally.
- Async reset: assert rst mid M2-high with 2 entries queued → outputs 0 immediately; after release with m2 already low → no spurious push.

Source files
------------

// File: rtl/map_bus_wr_capture_if.sv
// Write-record handshake between the bus capture front end and the mapper register file.
// The master drives the FIFO head record; the slave pops it with wr_ready.
interface map_bus_wr_capture_if;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/map_bus_wr_capture.sv
// Samples the asynchronous cartridge CPU bus and detects qualified M2 falling edges.
// In-window writes are queued as {addr, data} records for the mapper core.
module map_bus_wr_capture #(
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_HIGH    = 3,
    parameter logic [15:0] ADDR_MASK   = 16'h8000,
    parameter logic [15:0] ADDR_MATCH  = 16'h8000,
    parameter int          DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m2,
    input  logic                      cpu_rw,
    input  logic [15:0]               cpu_addr,
    input  logic [7:0]                cpu_data,
    input  logic                      hold,
    map_bus_wr_capture_if.master      wr,
    output logic [$clog2(DEPTH):0]    fifo_cnt,
    output logic                      ovf,
    input  logic                      ovf_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(MIN_HIGH + 1);
    localparam int BW = 25;
    localparam logic [HW-1:0] HI_SAT    = HW'(MIN_HIGH);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(DEPTH);

    logic [SYNC_STAGES-1:0]         m2_sync_q, m2_sync_d;
    logic [SYNC_STAGES-1:0][BW-1:0] bus_pipe_q, bus_pipe_d;
    logic                           m2_d_q, m2_d_d;
    logic [HW-1:0]                  hi_cnt_q, hi_cnt_d;
    logic [BW-1:0]                  cap_q, cap_d;
    logic [DEPTH-1:0][23:0]         mem_q, mem_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]                    cnt_q, cnt_d, cnt_rem_s;
    logic                           ovf_q, ovf_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [15:0]                    wr_addr_q, wr_addr_d;
    logic [7:0]                     wr_data_q, wr_data_d;
    logic                           m2_s, fall_s, in_win_s, accept_s, pop_s, full_s, push_s, drop_s;
    logic [BW-1:0]                  bus_s;

    // Next-state logic: synchronizer, capture, edge qualification and FIFO bookkeeping.
    always_comb begin
        m2_sync_d  = {m2_sync_q[SYNC_STAGES-2:0], m2};
        bus_pipe_d = {bus_pipe_q[SYNC_STAGES-2:0], {cpu_rw, cpu_addr, cpu_data}};
        m2_s       = m2_sync_q[SYNC_STAGES-1];
        bus_s      = bus_pipe_q[SYNC_STAGES-1];
        m2_d_d     = m2_s;

        if (!m2_s) begin
            hi_cnt_d = '0;
        end else if (hi_cnt_q == HI_SAT) begin
            hi_cnt_d = hi_cnt_q;
        end else begin
            hi_cnt_d = hi_cnt_q + HW'(1);
        end
        cap_d = m2_s ? bus_s : cap_q;

        // hi_cnt_q still holds the high-phase length on the first low cycle.
        fall_s   = m2_d_q & ~m2_s & (hi_cnt_q >= HI_SAT);
        in_win_s = (cap_q[23:8] & ADDR_MASK) == ADDR_MATCH;
        accept_s = fall_s & ~cap_q[24] & in_win_s & ~hold;

        pop_s  = wr_valid_q & wr.wr_ready;
        full_s = (cnt_q == CNT_FULL);
        push_s = accept_s & (~full_s | pop_s);
        drop_s = accept_s & full_s & ~pop_s;

        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = cap_q[23:0];
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // Head register ignores this cycle's push so a new record never bypasses.
        cnt_rem_s  = cnt_q - {{PW{1'b0}}, pop_s};
        wr_valid_d = (cnt_rem_s != '0);
        if (wr_valid_d) begin
            wr_addr_d = mem_q[rd_ptr_d][23:8];
            wr_data_d = mem_q[rd_ptr_d][7:0];
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_sync_q  <= '0;
            bus_pipe_q <= '0;
            m2_d_q     <= 1'b0;
            hi_cnt_q   <= '0;
            cap_q      <= '0;
            mem_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 16'h0000;
            wr_data_q  <= 8'h00;
        end else begin
            m2_sync_q  <= m2_sync_d;
            bus_pipe_q <= bus_pipe_d;
            m2_d_q     <= m2_d_d;
            hi_cnt_q   <= hi_cnt_d;
            cap_q      <= cap_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign fifo_cnt    = cnt_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_map_bus_wr_capture.sv
// Directed bench for map_bus_wr_capture: latency, filtering, overflow, full push+pop, hold, reset.
module tb_map_bus_wr_capture;
    logic        clk;
    logic        rst;
    logic        m2;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        hold;
    logic [2:0]  fifo_cnt;
    logic        ovf;
    logic        ovf_clr;
    int          checks_cnt;
    int          errors_cnt;

    map_bus_wr_capture_if wr_if ();

    map_bus_wr_capture dut (
        .clk      (clk),
        .rst      (rst),
        .m2       (m2),
        .cpu_rw   (cpu_rw),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .hold     (hold),
        .wr       (wr_if),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full CPU cycle: M2 high for hi clks, then low long enough for the record to reach the head.
    task automatic bus_wr(input logic rw, input logic [15:0] a, input logic [7:0] d, input int hi);
        @(negedge clk);
        cpu_rw = rw; cpu_addr = a; cpu_data = d; m2 = 1'b1;
        repeat (hi) @(negedge clk);
        m2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] a, input logic [7:0] d);
        check({tag, "_valid"}, {31'd0, wr_if.wr_valid}, 32'd1);
        check({tag, "_addr"}, {16'd0, wr_if.wr_addr}, {16'd0, a});
        check({tag, "_data"}, {24'd0, wr_if.wr_data}, {24'd0, d});
        wr_if.wr_ready = 1'b1;
        @(negedge clk);
        wr_if.wr_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks_cnt = 0; errors_cnt = 0;
        rst = 1'b1; m2 = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00;
        hold = 1'b0; ovf_clr = 1'b0; wr_if.wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("rst_addr", {16'd0, wr_if.wr_addr}, 32'd0);
        check("rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rel_cnt", {29'd0, fifo_cnt}, 32'd0);

        // Single write with exact latency: raw low sampled at edge k, valid after k+3.
        @(negedge clk);
        cpu_rw = 1'b0; cpu_addr = 16'h8001; cpu_data = 8'h5A; m2 = 1'b1;
        repeat (8) @(negedge clk);
        m2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("lat_early_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("lat_push_cnt", {29'd0, fifo_cnt}, 32'd1);
        @(posedge clk);
        #1;
        check("lat_valid", {31'd0, wr_if.wr_valid}, 32'd1);
        check("lat_addr", {16'd0, wr_if.wr_addr}, 32'h8001);
        check("lat_data", {24'd0, wr_if.wr_data}, 32'h5A);
        repeat (3) @(negedge clk);
        check("stable_addr", {16'd0, wr_if.wr_addr}, 32'h8001);
        pop_expect("single", 16'h8001, 8'h5A);
        check("single_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("single_empty", {31'd0, wr_if.wr_valid}, 32'd0);
        check("empty_hold_addr", {16'd0, wr_if.wr_addr}, 32'h8001);

        // Glitch, out-of-window and read cycles must never push.
        bus_wr(1'b0, 16'h8000, 8'h11, 2);
        check("glitch_cnt", {29'd0, fifo_cnt}, 32'd0);
        bus_wr(1'b0, 16'h6000, 8'h22, 8);
        check("window_cnt", {29'd0, fifo_cnt}, 32'd0);
        bus_wr(1'b1, 16'h8000, 8'h33, 8);
        check("read_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("filter_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        bus_wr(1'b0, 16'h8000, 8'h44, 3);
        check("minhigh_cnt", {29'd0, fifo_cnt}, 32'd1);
        pop_expect("minhigh", 16'h8000, 8'h44);

        // Overflow: fifth write is dropped, order preserved, ovf sticky.
        for (int i = 0; i < 5; i++) bus_wr(1'b0, 16'hE000 + 16'(i), 8'h10 + 8'(i), 8);
        check("ovf_cnt", {29'd0, fifo_cnt}, 32'd4);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 16'hE000 + 16'(i), 8'h10 + 8'(i));
        check("ovf_drained", {29'd0, fifo_cnt}, 32'd0);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, ovf}, 32'd0);

        // Full FIFO with pop on the accept cycle: both happen.
        for (int i = 0; i < 4; i++) bus_wr(1'b0, 16'hD000 + 16'(i), 8'h20 + 8'(i), 6);
        check("full_cnt", {29'd0, fifo_cnt}, 32'd4);
        @(negedge clk);
        cpu_rw = 1'b0; cpu_addr = 16'hF001; cpu_data = 8'h77; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0;
        repeat (2) @(negedge clk);
        wr_if.wr_ready = 1'b1;
        @(negedge clk);
        wr_if.wr_ready = 1'b0;
        check("fullpp_ovf", {31'd0, ovf}, 32'd0);
        check("fullpp_cnt", {29'd0, fifo_cnt}, 32'd4);
        @(negedge clk);
        for (int i = 1; i < 4; i++) pop_expect("fullpp_pop", 16'hD000 + 16'(i), 8'h20 + 8'(i));
        pop_expect("fullpp_last", 16'hF001, 8'h77);
        check("fullpp_empty", {29'd0, fifo_cnt}, 32'd0);

        // hold discards the edge without overflow; earlier entry still pops.
        bus_wr(1'b0, 16'hC000, 8'h55, 8);
        hold = 1'b1;
        bus_wr(1'b0, 16'hA000, 8'h66, 8);
        hold = 1'b0;
        check("hold_cnt", {29'd0, fifo_cnt}, 32'd1);
        check("hold_ovf", {31'd0, ovf}, 32'd0);
        pop_expect("hold_pop", 16'hC000, 8'h55);
        check("hold_empty", {29'd0, fifo_cnt}, 32'd0);

        // Async reset mid M2-high with two queued entries.
        bus_wr(1'b0, 16'hB000, 8'h01, 8);
        bus_wr(1'b0, 16'hB001, 8'h02, 8);
        check("pre_rst_cnt", {29'd0, fifo_cnt}, 32'd2);
        @(negedge clk);
        cpu_rw = 1'b0; cpu_addr = 16'h8123; cpu_data = 8'h99; m2 = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("arst_addr", {16'd0, wr_if.wr_addr}, 32'd0);
        check("arst_data", {24'd0, wr_if.wr_data}, 32'd0);
        check("arst_cnt", {29'd0, fifo_cnt}, 32'd0);
        m2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("post_rst_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("post_rst_ovf", {31'd0, ovf}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
